nts_tx_mac_driver: RTL and testbench

NTS_TX_MAC_DRIVER -- requirements
Module: nts_tx_mac_driver

---
 rtl/nts_tx_mac_driver.sv | 188 ++++++++++++++++++
 tb/tb_nts_tx_mac_driver.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nts_tx_mac_driver.sv
// nts_tx_mac_driver
// Moves one packet at a time from the engine TX FIFO to the MAC TX port.
// The first word is held with o_mac_tx_start until the MAC acks it; the rest
// of the frame then streams one word per cycle. A one-word buffer absorbs the
// word prefetched while waiting for the ack, so there is no bubble after it.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a complete packet (or discarding an empty one)
// FETCH    | two cycles: read word1, then register it and prefetch word2
// WAIT_ACK | word1 presented with start=1, held until the MAC acks
// STREAM   | one word per cycle until the last word has been presented
// RELEASE  | bus idle, packet released back to the engine (one cycle)
// GAP      | IFG_CYCLES idle cycles before the next frame may start
module nts_tx_mac_driver #(
  parameter int MAC_DATA_WIDTH = 64,
  parameter int IFG_CYCLES     = 2
) (
  input  logic                      i_clk,
  input  logic                      i_areset,
  input  logic                      i_engine_packet_available,
  output logic                      o_engine_packet_read,
  input  logic                      i_engine_fifo_empty,
  output logic                      o_engine_fifo_rd_en,
  input  logic [MAC_DATA_WIDTH-1:0] i_engine_fifo_rd_data,
  input  logic [3:0]                i_engine_bytes_last_word,
  output logic                      o_mac_tx_start,
  input  logic                      i_mac_tx_ack,
  output logic [7:0]                o_mac_tx_data_valid,
  output logic [MAC_DATA_WIDTH-1:0] o_mac_tx_data,
  output logic                      o_busy,
  output logic [31:0]               o_tx_packets,
  output logic [31:0]               o_tx_discards
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ACK,
    STREAM,
    RELEASE,
    GAP
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(IFG_CYCLES - 1);

  state_t                    state_q;
  logic                      fetch_ph_q;
  logic                      rd_pend_q;
  logic [MAC_DATA_WIDTH-1:0] data_q;
  logic [7:0]                mask_q;
  logic                      last_q;
  logic                      start_q;
  logic [MAC_DATA_WIDTH-1:0] buf_q;
  logic                      buf_last_q;
  logic                      pkt_read_q;
  logic [31:0]               packets_q;
  logic [31:0]               discards_q;
  logic [3:0]                gap_cnt_q;

  logic                      rd_en;
  logic [MAC_DATA_WIDTH-1:0] ack_src_data;
  logic                      ack_src_last;

  // Top-N byte mask for a final word; 0 or anything above 8 means a full word.
  function automatic logic [7:0] word_mask(input logic last, input logic [3:0] n);
    if (!last || n == 4'd0 || n > 4'd8) return 8'hFF;
    return 8'hFF << (4'd8 - n);
  endfunction

  // Word presented after the ack: straight from the FIFO if it lands this
  // cycle, otherwise from the buffer that caught it earlier.
  assign ack_src_data = rd_pend_q ? i_engine_fifo_rd_data : buf_q;
  assign ack_src_last = rd_pend_q ? i_engine_fifo_empty   : buf_last_q;

  // Read strobe: never while empty, never past a word known to be last.
  always_comb begin
    rd_en = 1'b0;
    case (state_q)
      FETCH:    rd_en = !i_engine_fifo_empty;
      WAIT_ACK: rd_en = i_mac_tx_ack && !last_q && !i_engine_fifo_empty;
      STREAM:   rd_en = !last_q && !i_engine_fifo_empty;
      default:  rd_en = 1'b0;
    endcase
  end

  // Frame sequencer with registered outputs and event counters.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q    <= IDLE;
      fetch_ph_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      data_q     <= '0;
      mask_q     <= 8'h00;
      last_q     <= 1'b0;
      start_q    <= 1'b0;
      buf_q      <= '0;
      buf_last_q <= 1'b0;
      pkt_read_q <= 1'b0;
      packets_q  <= 32'd0;
      discards_q <= 32'd0;
      gap_cnt_q  <= 4'd0;
    end else begin
      pkt_read_q <= 1'b0;
      rd_pend_q  <= rd_en;
      case (state_q)
        IDLE: begin
          // Skip the pulse cycle so a just-discarded packet is not seen twice.
          if (i_engine_packet_available && !pkt_read_q) begin
            if (!i_engine_fifo_empty) begin
              state_q    <= FETCH;
              fetch_ph_q <= 1'b0;
            end else begin
              pkt_read_q <= 1'b1;
              discards_q <= discards_q + 32'd1;
            end
          end
        end
        FETCH: begin
          if (!fetch_ph_q) begin
            fetch_ph_q <= 1'b1;
          end else begin
            data_q  <= i_engine_fifo_rd_data;
            last_q  <= i_engine_fifo_empty;
            mask_q  <= word_mask(i_engine_fifo_empty, i_engine_bytes_last_word);
            start_q <= 1'b1;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (rd_pend_q) begin
            buf_q      <= i_engine_fifo_rd_data;
            buf_last_q <= i_engine_fifo_empty;
          end
          if (i_mac_tx_ack) begin
            start_q <= 1'b0;
            if (last_q) begin
              data_q     <= '0;
              mask_q     <= 8'h00;
              last_q     <= 1'b0;
              pkt_read_q <= 1'b1;
              packets_q  <= packets_q + 32'd1;
              state_q    <= RELEASE;
            end else begin
              data_q  <= ack_src_data;
              last_q  <= ack_src_last;
              mask_q  <= word_mask(ack_src_last, i_engine_bytes_last_word);
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (last_q) begin
            data_q     <= '0;
            mask_q     <= 8'h00;
            last_q     <= 1'b0;
            pkt_read_q <= 1'b1;
            packets_q  <= packets_q + 32'd1;
            state_q    <= RELEASE;
          end else begin
            data_q <= i_engine_fifo_rd_data;
            last_q <= i_engine_fifo_empty;
            mask_q <= word_mask(i_engine_fifo_empty, i_engine_bytes_last_word);
          end
        end
        RELEASE: begin
          gap_cnt_q <= GAP_LOAD;
          state_q   <= GAP;
        end
        GAP: begin
          if (gap_cnt_q == 4'd0) state_q <= IDLE;
          else                   gap_cnt_q <= gap_cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_engine_fifo_rd_en  = rd_en;
  assign o_engine_packet_read = pkt_read_q;
  assign o_mac_tx_start       = start_q;
  assign o_mac_tx_data_valid  = mask_q;
  assign o_mac_tx_data        = data_q;
  assign o_busy               = (state_q != IDLE);
  assign o_tx_packets         = packets_q;
  assign o_tx_discards        = discards_q;

endmodule

// File: tb/tb_nts_tx_mac_driver.sv
// Bench for nts_tx_mac_driver: an engine FIFO model feeds packets, a MAC model
// acks start after a chosen delay, and a scoreboard checks every accepted word.
module tb_nts_tx_mac_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        avail, pr, empty, rd_en, start, ack, busy;
  logic [63:0] rd_data, tx_data;
  logic [3:0]  bytes_lw;
  logic [7:0]  mask;
  logic [31:0] tx_packets, tx_discards;

  always #5 clk = ~clk;

  nts_tx_mac_driver #(.MAC_DATA_WIDTH(64), .IFG_CYCLES(2)) dut (
    .i_clk                     (clk),
    .i_areset                  (rst),
    .i_engine_packet_available (avail),
    .o_engine_packet_read      (pr),
    .i_engine_fifo_empty       (empty),
    .o_engine_fifo_rd_en       (rd_en),
    .i_engine_fifo_rd_data     (rd_data),
    .i_engine_bytes_last_word  (bytes_lw),
    .o_mac_tx_start            (start),
    .i_mac_tx_ack              (ack),
    .o_mac_tx_data_valid       (mask),
    .o_mac_tx_data             (tx_data),
    .o_busy                    (busy),
    .o_tx_packets              (tx_packets),
    .o_tx_discards             (tx_discards)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  mask;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] pend_words[$];
  int          pend_lens[$];
  logic [3:0]  pend_bytes[$];
  logic [63:0] cur_words[$];
  logic        cur_valid = 1'b0;
  logic [3:0]  cur_bytes = 4'd0;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, words = 0, frames = 0, pr_pulses = 0;
  int rd_viol = 0, data_viol = 0, bubble_viol = 0, hold_viol = 0, tail_viol = 0, pr_wide = 0;
  int last_start_len = 0, last_gap = 0, last_word_cyc = -1;
  int ack_delay = 1;
  bit stray_en = 1'b0;
  int exp_packets = 0, exp_discards = 0;

  function automatic logic [7:0] ref_mask(input int n);
    logic [7:0] m;
    m = 8'h00;
    if (n < 1 || n > 8) return 8'hFF;
    for (int i = 0; i < n; i++) m[7-i] = 1'b1;
    return m;
  endfunction

  task automatic queue_packet(input int len, input logic [3:0] nb);
    beat_t       b;
    logic [63:0] w;
    if (len == 0) exp_discards++;
    else          exp_packets++;
    for (int i = 0; i < len; i++) begin
      w = {$urandom, $urandom} | 64'h1;
      pend_words.push_back(w);
      b.data = w;
      b.last = (i == len - 1);
      b.mask = b.last ? ref_mask(int'(nb)) : 8'hFF;
      exp_q.push_back(b);
    end
    pend_lens.push_back(len);
    pend_bytes.push_back(nb);
  endtask

  // Engine FIFO + MAC model + scoreboard; samples at negedge, drives at posedge+1.
  task automatic run_model();
    bit          smp_rd, smp_pr, prev_start, prev_pr, expect_more, post_last, xfer;
    logic [63:0] prev_data;
    logic [7:0]  prev_mask;
    int          start_run, wait_cnt, n;
    beat_t       b;
    prev_start = 0; prev_pr = 0; expect_more = 0; post_last = 0;
    prev_data = '0; prev_mask = '0; start_run = 0; wait_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      smp_rd = rd_en;
      smp_pr = pr;
      if (rst) begin
        expect_more = 0; post_last = 0; prev_start = 0; prev_pr = 0; start_run = 0;
      end else begin
        if (pr) pr_pulses++;
        if (pr && prev_pr) pr_wide++;
        if (mask == 8'h00 && tx_data != 64'h0) data_viol++;
        if (start && !prev_start) begin
          frames++;
          if (last_word_cyc >= 0) last_gap = cyc - last_word_cyc - 1;
        end
        if (start && prev_start && (tx_data !== prev_data || mask !== prev_mask)) hold_viol++;
        start_run = start ? start_run + 1 : 0;
        if (start && ack) last_start_len = start_run;
        xfer = (mask != 8'h00) && (!start || ack);
        if (expect_more && !xfer) bubble_viol++;
        if (post_last && mask != 8'h00) tail_viol++;
        expect_more = 0;
        post_last   = 0;
        if (xfer) begin
          words++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: got word %0h expected none", tx_data);
          end else begin
            b = exp_q.pop_front();
            n_checks++;
            if (tx_data !== b.data) $display("FAIL sb_data: got %0h expected %0h", tx_data, b.data);
            else n_pass++;
            n_checks++;
            if (mask !== b.mask) $display("FAIL sb_mask: got %0h expected %0h", mask, b.mask);
            else n_pass++;
            if (b.last) begin post_last = 1; last_word_cyc = cyc; end
            else expect_more = 1;
          end
        end
        prev_pr = pr; prev_start = start; prev_data = tx_data; prev_mask = mask;
      end
      @(posedge clk);
      #1;
      if (smp_rd) begin
        if (cur_words.size() == 0) rd_viol++;
        else rd_data = cur_words.pop_front();
      end else begin
        rd_data = {$urandom, $urandom};
      end
      if (smp_pr) begin
        cur_valid = 1'b0;
        cur_words.delete();
      end
      if (!cur_valid && pend_lens.size() > 0) begin
        n = pend_lens.pop_front();
        cur_bytes = pend_bytes.pop_front();
        cur_words.delete();
        for (int i = 0; i < n; i++) cur_words.push_back(pend_words.pop_front());
        cur_valid = 1'b1;
      end
      avail    = cur_valid;
      empty    = (cur_words.size() == 0);
      bytes_lw = cur_bytes;
      if (start) begin
        ack = (wait_cnt >= ack_delay - 1);
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        ack = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && pend_lens.size() == 0 && !cur_valid && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; avail = 1'b0; empty = 1'b1; ack = 1'b0; rd_data = '0; bytes_lw = 4'd0;
    #1;
    n_checks++;
    if ({start, pr, busy, rd_en} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {start, pr, busy, rd_en});
    else n_pass++;
    n_checks++;
    if (mask !== 8'h00 || tx_data !== 64'h0)
      $display("FAIL reset_data: got mask %0h data %0h expected 0", mask, tx_data);
    else n_pass++;
    n_checks++;
    if (tx_packets !== 32'd0 || tx_discards !== 32'd0)
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", tx_packets, tx_discards);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_three_word();
    bit ok;
    int pr0;
    ack_delay = 2; stray_en = 0; pr0 = pr_pulses;
    queue_packet(3, 4'd3);
    wait_done(200, ok);
    n_checks++;
    if (!ok) $display("FAIL three_word_timeout: got busy expected done"); else n_pass++;
    n_checks++;
    if (last_start_len !== 2) $display("FAIL three_word_start_len: got %0d expected 2", last_start_len);
    else n_pass++;
    n_checks++;
    if (pr_pulses - pr0 !== 1) $display("FAIL three_word_pkt_read: got %0d expected 1", pr_pulses - pr0);
    else n_pass++;
    n_checks++;
    if (tx_packets !== 32'd1) $display("FAIL three_word_packets: got %0d expected 1", tx_packets);
    else n_pass++;
    n_checks++;
    if (bubble_viol !== 0) $display("FAIL three_word_bubble: got %0d expected 0", bubble_viol);
    else n_pass++;
  endtask

  task automatic test_single_word();
    bit ok;
    int pr0;
    ack_delay = 1; pr0 = pr_pulses;
    queue_packet(1, 4'd8);
    wait_done(200, ok);
    n_checks++;
    if (!ok) $display("FAIL single_timeout: got busy expected done"); else n_pass++;
    n_checks++;
    if (pr_pulses - pr0 !== 1) $display("FAIL single_pkt_read: got %0d expected 1", pr_pulses - pr0);
    else n_pass++;
    n_checks++;
    if (tx_packets !== 32'd2) $display("FAIL single_packets: got %0d expected 2", tx_packets);
    else n_pass++;
    n_checks++;
    if (tail_viol !== 0) $display("FAIL single_tail: got %0d expected 0", tail_viol);
    else n_pass++;
  endtask

  task automatic test_discard();
    bit ok;
    int pr0, f0;
    pr0 = pr_pulses; f0 = frames;
    queue_packet(0, 4'd5);
    wait_done(100, ok);
    n_checks++;
    if (!ok) $display("FAIL discard_timeout: got busy expected done"); else n_pass++;
    n_checks++;
    if (frames !== f0) $display("FAIL discard_start: got %0d starts expected 0", frames - f0);
    else n_pass++;
    n_checks++;
    if (pr_pulses - pr0 !== 1) $display("FAIL discard_pkt_read: got %0d expected 1", pr_pulses - pr0);
    else n_pass++;
    n_checks++;
    if (tx_discards !== 32'd1) $display("FAIL discard_count: got %0d expected 1", tx_discards);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    ack_delay = 1;
    queue_packet(2, 4'd6);
    queue_packet(4, 4'd1);
    wait_done(300, ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_timeout: got busy expected done"); else n_pass++;
    n_checks++;
    if (last_gap < 3) $display("FAIL b2b_gap: got %0d expected at least 3", last_gap);
    else n_pass++;
    n_checks++;
    if (tx_packets !== 32'd4) $display("FAIL b2b_packets: got %0d expected 4", tx_packets);
    else n_pass++;
  endtask

  task automatic test_stray_ack_masks();
    bit         ok;
    logic [3:0] nbs[8];
    nbs = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd12};
    stray_en = 1; ack_delay = 3;
    for (int i = 0; i < 8; i++) queue_packet($urandom_range(1, 5), nbs[i]);
    wait_done(2000, ok);
    stray_en = 0;
    n_checks++;
    if (!ok) $display("FAIL stray_timeout: got busy expected done"); else n_pass++;
    n_checks++;
    if (tx_packets !== 32'(exp_packets)) $display("FAIL stray_packets: got %0d expected %0d", tx_packets, exp_packets);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    int w0, pr0;
    ack_delay = 1; w0 = words; ok = 0;
    queue_packet(6, 4'd4);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (words >= w0 + 2) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) $display("FAIL rst_stream_reach: got %0d words expected 2", words - w0); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({start, pr, busy, rd_en} !== 4'b0000 || mask !== 8'h00 || tx_data !== 64'h0)
      $display("FAIL rst_stream_outputs: got ctrl %b mask %0h expected 0", {start, pr, busy, rd_en}, mask);
    else n_pass++;
    n_checks++;
    if (tx_packets !== 32'd0) $display("FAIL rst_stream_counter: got %0d expected 0", tx_packets);
    else n_pass++;
    pr0 = pr_pulses;
    repeat (2) @(negedge clk);
    #2;
    cur_valid = 1'b0;
    cur_words.delete();
    exp_q.delete();
    exp_packets = 0; exp_discards = 0;
    rst = 1'b0;
    queue_packet(3, 4'd7);
    wait_done(300, ok);
    n_checks++;
    if (!ok) $display("FAIL rst_next_timeout: got busy expected done"); else n_pass++;
    n_checks++;
    if (pr_pulses - pr0 !== 1) $display("FAIL rst_pkt_read: got %0d expected 1", pr_pulses - pr0);
    else n_pass++;
    n_checks++;
    if (tx_packets !== 32'd1) $display("FAIL rst_next_packets: got %0d expected 1", tx_packets);
    else n_pass++;
  endtask

  task automatic test_invariants();
    n_checks++;
    if (rd_viol !== 0) $display("FAIL rd_when_empty: got %0d expected 0", rd_viol); else n_pass++;
    n_checks++;
    if (data_viol !== 0) $display("FAIL data_when_mask0: got %0d expected 0", data_viol); else n_pass++;
    n_checks++;
    if (bubble_viol !== 0) $display("FAIL bubble: got %0d expected 0", bubble_viol); else n_pass++;
    n_checks++;
    if (hold_viol !== 0) $display("FAIL start_hold: got %0d expected 0", hold_viol); else n_pass++;
    n_checks++;
    if (tail_viol !== 0) $display("FAIL tail_mask: got %0d expected 0", tail_viol); else n_pass++;
    n_checks++;
    if (pr_wide !== 0) $display("FAIL pkt_read_width: got %0d expected 0", pr_wide); else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    fork
      run_model();
      begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_three_word();
    test_single_word();
    test_discard();
    test_back_to_back();
    test_stray_ack_masks();
    test_reset_mid_stream();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
